// File: rtl/avalon_bus_arbiter.sv
// Two-master Avalon-MM arbiter sharing one slave, with a wait-cycle timeout abort.
// Define ARB_ROUND_ROBIN_EN for a toggling priority pointer; otherwise master 1 has fixed priority.
module avalon_bus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  // state | meaning
  // IDLE  | no owner, arbitrate pending requests
  // OWN0  | master 0 drives the slave
  // OWN1  | master 1 drives the slave
  // ABORT | one-cycle error response to the timed-out owner
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;

  localparam logic [8:0]  TIMEOUT_W  = TIMEOUT[8:0];
  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

  state_t     state_q, state_d;
  logic [8:0] wait_cnt_q, wait_cnt_d;
  logic       abort_owner_q, abort_owner_d;
  logic       req0, req1, own_req, win1;
  logic [8:0] wait_inc;

  assign req0     = m0_read | m0_write;
  assign req1     = m1_read | m1_write;
  assign own_req  = (state_q == OWN1) ? req1 : req0;
  assign wait_inc = wait_cnt_q + 9'd1;

`ifdef ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;
  logic xfer_end;

  assign win1 = req1 & (~req0 | ptr_q);
  // In an owned state with the request held, any state change is a completion or abort.
  assign xfer_end = ((state_q == OWN0) || (state_q == OWN1)) && own_req && (state_d != state_q);
  assign ptr_d    = ptr_q ^ xfer_end;
`else
  assign win1 = req1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      abort_owner_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      abort_owner_q <= abort_owner_d;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q         <= ptr_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    abort_owner_d  = abort_owner_q;
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_waitrequest = 1'b1;
    m1_readdata    = '0;
    grant          = 2'b00;
    timeout_err    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d    = win1 ? OWN1 : OWN0;
          wait_cnt_d = '0;
        end
      end
      OWN0, OWN1: begin
        if (!own_req) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          state_d = IDLE;
        end else if (wait_inc == TIMEOUT_W) begin
          state_d       = ABORT;
          wait_cnt_d    = wait_inc;
          abort_owner_d = (state_q == OWN1);
        end else begin
          wait_cnt_d = wait_inc;
        end

        if (state_q == OWN0) begin
          grant        = 2'b01;
          s_address    = m0_address;
          s_read       = m0_read;
          s_write      = m0_write & ~m0_read;
          s_writedata  = m0_writedata;
          s_byteenable = m0_byteenable;
          if (req0) begin
            m0_waitrequest = s_waitrequest;
            m0_readdata    = s_readdata;
          end
        end else begin
          grant        = 2'b10;
          s_address    = m1_address;
          s_read       = m1_read;
          s_write      = m1_write & ~m1_read;
          s_writedata  = m1_writedata;
          s_byteenable = m1_byteenable;
          if (req1) begin
            m1_waitrequest = s_waitrequest;
            m1_readdata    = s_readdata;
          end
        end
      end
      ABORT: begin
        state_d     = IDLE;
        timeout_err = 1'b1;
        if (abort_owner_q) begin
          m1_waitrequest = 1'b0;
          m1_readdata    = ABORT_DATA;
        end else begin
          m0_waitrequest = 1'b0;
          m0_readdata    = ABORT_DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Self-checking bench for avalon_bus_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_avalon_bus_arbiter;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata, s_readdata;
  logic        m0_read, m0_write, m1_read, m1_write, s_waitrequest;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest, s_read, s_write, timeout_err;
  logic [31:0] m0_readdata, m1_readdata, s_address, s_writedata;
  logic [3:0]  s_byteenable;
  logic [1:0]  grant;

  always #5 clk = ~clk;

  avalon_bus_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the bus, how long it has waited, pending abort response.
  bit mdl_valid = 1'b0;
  int mdl_owner = -1;
  bit mdl_abort = 1'b0;
  int mdl_abort_owner = 0;
  int mdl_waits = 0;
  int mdl_ptr = 0;
  int mdl_last_done = -1;
  int mdl_last_abort = -1;

  bit         log_en = 1'b0;
  logic [1:0] prev_grant = 2'b00;
  logic [1:0] grant_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    bit         rd[2], wr[2], rq[2];
    logic [31:0] ad[2], wd[2];
    logic [3:0] be[2];
    logic [1:0] eg;
    logic [31:0] e_addr, e_wd;
    logic [3:0] e_be;
    bit         e_rd, e_wr, e_wait[2];
    logic [31:0] e_rdata[2], o_rdata[2];
    bit         o_wait[2];
    rd[0] = m0_read;  wr[0] = m0_write;  ad[0] = m0_address; wd[0] = m0_writedata; be[0] = m0_byteenable;
    rd[1] = m1_read;  wr[1] = m1_write;  ad[1] = m1_address; wd[1] = m1_writedata; be[1] = m1_byteenable;
    o_wait[0] = m0_waitrequest; o_rdata[0] = m0_readdata;
    o_wait[1] = m1_waitrequest; o_rdata[1] = m1_readdata;
    eg = 2'b00; e_addr = '0; e_wd = '0; e_be = '0; e_rd = 1'b0; e_wr = 1'b0;
    if (mdl_owner >= 0) begin
      eg     = (mdl_owner == 0) ? 2'b01 : 2'b10;
      e_addr = ad[mdl_owner];
      e_wd   = wd[mdl_owner];
      e_be   = be[mdl_owner];
      e_rd   = rd[mdl_owner];
      e_wr   = wr[mdl_owner] & ~rd[mdl_owner];
    end
    for (int n = 0; n < 2; n++) begin
      rq[n] = rd[n] | wr[n];
      if (mdl_abort && mdl_abort_owner == n) begin
        e_wait[n] = 1'b0; e_rdata[n] = 32'hDEADBEEF;
      end else if (mdl_owner == n && rq[n]) begin
        e_wait[n] = s_waitrequest; e_rdata[n] = s_readdata;
      end else begin
        e_wait[n] = 1'b1; e_rdata[n] = 32'h0;
      end
      chk($sformatf("mdl_m%0d_waitrequest", n), {31'b0, o_wait[n]}, {31'b0, e_wait[n]});
      chk($sformatf("mdl_m%0d_readdata", n), o_rdata[n], e_rdata[n]);
    end
    chk("mdl_grant", {30'b0, grant}, {30'b0, eg});
    chk("mdl_s_read", {31'b0, s_read}, {31'b0, e_rd});
    chk("mdl_s_write", {31'b0, s_write}, {31'b0, e_wr});
    chk("mdl_s_address", s_address, e_addr);
    chk("mdl_s_writedata", s_writedata, e_wd);
    chk("mdl_s_byteenable", {28'b0, s_byteenable}, {28'b0, e_be});
    chk("mdl_timeout_err", {31'b0, timeout_err}, {31'b0, mdl_abort});
  endtask

  task automatic model_update();
    bit rq[2];
    int o;
    rq[0] = m0_read | m0_write;
    rq[1] = m1_read | m1_write;
    mdl_last_done  = -1;
    mdl_last_abort = -1;
    if (!reset) begin
      mdl_valid = 1'b1; mdl_owner = -1; mdl_abort = 1'b0; mdl_waits = 0; mdl_ptr = 0;
    end else if (mdl_valid) begin
      if (mdl_abort) begin
        mdl_abort = 1'b0;
      end else if (mdl_owner < 0) begin
        if (rq[0] && rq[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
          mdl_owner = mdl_ptr;
`else
          mdl_owner = 1;
`endif
          mdl_waits = 0;
        end else if (rq[0] || rq[1]) begin
          mdl_owner = rq[1] ? 1 : 0;
          mdl_waits = 0;
        end
      end else begin
        o = mdl_owner;
        if (!rq[o]) begin
          mdl_owner = -1;
        end else if (!s_waitrequest) begin
          mdl_last_done = o; mdl_owner = -1; mdl_ptr = 1 - mdl_ptr;
        end else begin
          mdl_waits++;
          if (mdl_waits == TMO) begin
            mdl_abort = 1'b1; mdl_abort_owner = o; mdl_last_abort = o;
            mdl_owner = -1; mdl_ptr = 1 - mdl_ptr;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (mdl_valid) model_check();
    if (log_en && grant != 2'b00 && grant != prev_grant) grant_log.push_back(grant);
    prev_grant = grant;
    @(posedge clk);
    model_update();
    #1;
  endtask

  int stall = 0;
  int cyc;

  initial begin
    reset = 1'b0;
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
    s_waitrequest = 1'b0; s_readdata = '0;
    step();
    #1;
    chk("rst_grant", {30'b0, grant}, 32'h0);
    chk("rst_s_read", {31'b0, s_read}, 32'h0);
    chk("rst_m0_wait", {31'b0, m0_waitrequest}, 32'h1);
    chk("rst_timeout_err", {31'b0, timeout_err}, 32'h0);
    step();
    reset = 1'b1;
    step();

    // m0 read with two wait cycles
    m0_read = 1; m0_address = 32'h10; s_waitrequest = 1; s_readdata = 32'h24020010;
    #1 chk("rd_idle_grant", {30'b0, grant}, 32'h0);
    step();
    #1 chk("rd_grant_k1", {30'b0, grant}, 32'h1);
    chk("rd_s_read", {31'b0, s_read}, 32'h1);
    chk("rd_s_address", s_address, 32'h10);
    step();
    #1 chk("rd_wait2", {31'b0, m0_waitrequest}, 32'h1);
    step();
    s_waitrequest = 0;
    #1 chk("rd_done_wait", {31'b0, m0_waitrequest}, 32'h0);
    chk("rd_done_data", m0_readdata, 32'h24020010);
    step();
    m0_read = 0;
    #1 chk("rd_after_grant", {30'b0, grant}, 32'h0);
    step();

    // m1 partial-lane write
    m1_write = 1; m1_address = 32'h200; m1_byteenable = 4'b0011; m1_writedata = 32'h0000BEEF;
    s_waitrequest = 1;
    step();
    s_waitrequest = 0;
    #1 chk("be_grant", {30'b0, grant}, 32'h2);
    chk("be_s_byteenable", {28'b0, s_byteenable}, 32'h3);
    chk("be_s_writedata", s_writedata, 32'h0000BEEF);
    chk("be_s_write", {31'b0, s_write}, 32'h1);
    step();
    m1_write = 0;
    step();

    // four back-to-back simultaneous write pairs, starting from a fresh pointer
    reset = 0; step(); reset = 1;
    s_waitrequest = 0; m0_address = 32'h100; m0_byteenable = 4'hF;
    grant_log.delete();
    log_en = 1'b1;
    for (int p = 0; p < 4; p++) begin
      m0_write = 1; m1_write = 1;
      m0_writedata = $urandom(); m1_writedata = $urandom();
      cyc = 0;
      while ((m0_write || m1_write) && cyc < 20) begin
        step();
        cyc++;
        if (mdl_last_done == 0) m0_write = 0;
        if (mdl_last_done == 1) m1_write = 0;
      end
      chk("pair_bound", {31'b0, m0_write | m1_write}, 32'h0);
      m0_write = 0; m1_write = 0;
    end
    step();
    log_en = 1'b0;
    chk("pair_grant_count", grant_log.size(), 32'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      chk($sformatf("pair_order_%0d", i), {30'b0, grant_log[i]}, (i % 2 == 0) ? 32'h1 : 32'h2);
`else
      chk($sformatf("pair_order_%0d", i), {30'b0, grant_log[i]}, (i % 2 == 0) ? 32'h2 : 32'h1);
`endif
    end

    // slave stalls forever: abort after TMO waited cycles
    m0_read = 1; m0_address = 32'h44; s_waitrequest = 1;
    step();
    for (int i = 0; i < TMO; i++) begin
      #1 chk("tmo_no_err", {31'b0, timeout_err}, 32'h0);
      step();
    end
    #1 chk("tmo_err", {31'b0, timeout_err}, 32'h1);
    chk("tmo_rdata", m0_readdata, 32'hDEADBEEF);
    chk("tmo_wait", {31'b0, m0_waitrequest}, 32'h0);
    chk("tmo_grant", {30'b0, grant}, 32'h0);
    chk("tmo_s_read", {31'b0, s_read}, 32'h0);
    step();
    m0_read = 0;
    #1 chk("tmo_err_pulse", {31'b0, timeout_err}, 32'h0);
    step();

    // reset on the second wait cycle of an m1 write
    m1_write = 1; m1_writedata = 32'h12345678; s_waitrequest = 1;
    step();
    #1 chk("rstx_wait1", {31'b0, m1_waitrequest}, 32'h1);
    step();
    reset = 0;
    #1 chk("rstx_wait2", {31'b0, m1_waitrequest}, 32'h1);
    step();
    reset = 1; m1_write = 0;
    #1 chk("rstx_s_write", {31'b0, s_write}, 32'h0);
    chk("rstx_grant", {30'b0, grant}, 32'h0);
    step();

    // owner drops its read while the other master waits
    m0_read = 1; m0_address = 32'h80; s_waitrequest = 1;
    step();
    m1_read = 1; m1_address = 32'h90;
    #1 chk("drop_grant0", {30'b0, grant}, 32'h1);
    step();
    m0_read = 0;
    #1 chk("drop_still0", {30'b0, grant}, 32'h1);
    chk("drop_m1_wait", {31'b0, m1_waitrequest}, 32'h1);
    step();
    #1 chk("drop_idle", {30'b0, grant}, 32'h0);
    chk("drop_no_err", {31'b0, timeout_err}, 32'h0);
    step();
    s_waitrequest = 0; s_readdata = 32'hCAFE0001;
    #1 chk("drop_grant1", {30'b0, grant}, 32'h2);
    chk("drop_m1_data", m1_readdata, 32'hCAFE0001);
    step();
    m1_read = 0;
    step();

    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 99) != 0);
      if (stall > 0) begin
        s_waitrequest = 1; stall--;
      end else begin
        s_waitrequest = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 24) == 0) stall = $urandom_range(5, 12);
      end
      s_readdata = $urandom();
      if (mdl_last_done == 0 || mdl_last_abort == 0) begin
        m0_read = 0; m0_write = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        m0_read = 1'($urandom_range(0, 1)); m0_write = 1'($urandom_range(0, 1));
        m0_address = $urandom(); m0_writedata = $urandom(); m0_byteenable = 4'($urandom_range(0, 15));
      end
      if (mdl_last_done == 1 || mdl_last_abort == 1) begin
        m1_read = 0; m1_write = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        m1_read = 1'($urandom_range(0, 1)); m1_write = 1'($urandom_range(0, 1));
        m1_address = $urandom(); m1_writedata = $urandom(); m1_byteenable = 4'($urandom_range(0, 15));
      end
      step();
    end

    reset = 1; m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0; s_waitrequest = 0;
    step(); step(); step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/avalon_bus_arbiter.md
AVALON_BUS_ARBITER -- requirements
Module: avalon_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum consecutive slave waitrequest cycles before a transfer is aborted.
REQ-002 SHALL have ports clk (input, 1) and reset (input, 1): single clock; synchronous, active-low reset.
REQ-003 SHALL have mN_address (input, 32, N=0,1): master N word address; master 0 is the CPU, master 1 is the loader/debug port.
REQ-004 SHALL have mN_read and mN_write (input, 1 each): master N read and write requests.
REQ-005 SHALL have mN_writedata (input, 32) and mN_byteenable (input, 4): master N write data and byte lanes.
REQ-006 SHALL have mN_waitrequest (output, 1) and mN_readdata (output, 32): master N stall and returned read data.
REQ-007 SHALL have s_address (output, 32), s_read and s_write (output, 1 each), s_writedata (output, 32), s_byteenable (output, 4): shared-slave command outputs.
REQ-008 SHALL have s_waitrequest (input, 1) and s_readdata (input, 32): shared-slave response.
REQ-009 SHALL have grant (output, 2): one-hot owner, bit N = master N; 2'b00 when idle.
REQ-010 SHALL have timeout_err (output, 1): one-cycle pulse on an aborted transfer.

Function
REQ-011 SHALL implement FSM states IDLE, OWN0, OWN1, ABORT.
REQ-012 Request of master N SHALL be mN_read|mN_write; mN_read and mN_write both high SHALL be treated as a read.
REQ-013 In IDLE with request(s) at cycle k, SHALL register the winner's OWN state so the slave sees the command at cycle k+1.
REQ-014 In OWNn, s_* commands SHALL combinationally mirror master n's inputs; mn_waitrequest = s_waitrequest; mn_readdata = s_readdata.
REQ-015 Every non-owning master with a request SHALL see waitrequest=1; a master with no request SHALL see waitrequest=1 and readdata=0.
REQ-016 In IDLE, s_read=s_write=0, s_address/s_writedata/s_byteenable=0, and both mN_waitrequest=1.
REQ-017 A transfer SHALL complete on the cycle s_read|s_write is high and s_waitrequest=0; the FSM SHALL return to IDLE the next cycle (one bubble cycle between grants).
REQ-018 An owner that drops its request before completion SHALL release the grant next cycle (return to IDLE) with no error.
REQ-019 A 9-bit wait counter SHALL clear on grant and increment on each owned cycle with s_waitrequest=1; on reaching TIMEOUT it SHALL enter ABORT.
REQ-020 ABORT SHALL last one cycle: s_read=s_write=0, owner waitrequest=0, owner readdata=32'hDEADBEEF, timeout_err=1; then IDLE.
REQ-021 Only the owning master's request SHALL affect the FSM in OWNn; the other master's request changes SHALL be ignored until IDLE.

Reset
REQ-022 With reset=0 on a rising clk edge, FSM SHALL go to IDLE, grant=2'b00, wait counter=0, priority pointer=master 0, timeout_err=0.
REQ-023 Reset mid-transfer SHALL drop s_read/s_write the cycle after the sampling edge without completing the transfer.
REQ-024 After reset, all outputs SHALL hold IDLE values (REQ-016) until the first post-reset arbitration.

Configuration
REQ-025 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL go to the master pointed to by a 1-bit priority pointer, which toggles to the other master after each completed or aborted transfer.
REQ-026 Without ARB_ROUND_ROBIN_EN, master 1 SHALL always win simultaneous requests (fixed priority) and no pointer register SHALL exist.

Verification
REQ-027 Only m0 read of 0x10, slave readdata 0x24020010 after 2 wait cycles -> grant=01 at k+1, m0_readdata=0x24020010 on the completion cycle, grant=00 the next cycle.
REQ-028 m0 and m1 both write in the same cycle -> fixed mode: m1 served first, then m0 after one bubble; RR mode: alternating order over 4 back-to-back pairs.
REQ-029 Slave holds waitrequest=1 indefinitely, TIMEOUT=8 -> ABORT after 8 waited cycles, timeout_err one-cycle pulse, m0_readdata=0xDEADBEEF, grant=00.
REQ-030 Reset asserted on the 2nd wait cycle of an m1 write -> s_write=0 and grant=00 on the next cycle, no completion seen by m1.
REQ-031 m0 drops read before completion while m1 requests -> OWN0 -> IDLE -> OWN1, no timeout_err.
REQ-032 m1 byteenable=4'b0011, data 0x0000BEEF -> s_byteenable and s_writedata match bit-exact while grant=10.
